// File: rtl/acc_word_sequencer.sv
// rtl/acc_word_sequencer.sv - G-15 accumulator word-time sequencer with drum bit/word timing
module acc_word_sequencer #(
    parameter int WORD_BITS  = 29,
    parameter int DRUM_WORDS = 108
) (
    input  logic       CLOCK,
    input  logic       rst_n,
    input  logic       bit_tick,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [6:0] count,
    input  logic       abort,
    output logic       T1,
    output logic       T29,
    output logic       CE,
    output logic [6:0] word_num,
    output logic       TR,
    output logic       DU,
    output logic       KEY_RETURN,
    output logic       SHIFT_INC,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [4:0] LAST_BIT  = 5'(WORD_BITS - 1);
    localparam logic [6:0] LAST_WORD = 7'(DRUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    logic [4:0] bit_cnt;
    logic       word_end;
    state_t     state, state_n;
    logic [1:0] op_r, op_n;
    logic [6:0] remaining, rem_n;
    logic       in_run;

    assign word_end = bit_tick && (bit_cnt == LAST_BIT);

    // Drum timing: bit counter within the word and word number within the revolution
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 5'd0;
            word_num <= 7'd0;
        end else if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
                bit_cnt  <= 5'd0;
                word_num <= (word_num == LAST_WORD) ? 7'd0 : word_num + 7'd1;
            end else begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    // Sequencer state, latched operation and remaining word count
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_r      <= 2'b00;
            remaining <= 7'd0;
        end else begin
            state     <= state_n;
            op_r      <= op_n;
            remaining <= rem_n;
        end
    end

    // Next-state logic: abort always beats a coincident final word end
    always_comb begin
        state_n = state;
        op_n    = op_r;
        rem_n   = remaining;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count == 7'd0) begin
                        state_n = S_ERR;
                    end else begin
                        op_n    = op;
                        rem_n   = count;
                        state_n = word_end ? S_RUN : S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (abort) begin
                    state_n = S_IDLE;
                    rem_n   = 7'd0;
                end else if (word_end) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_n = S_IDLE;
                    rem_n   = 7'd0;
                end else if (word_end) begin
                    rem_n = remaining - 7'd1;
                    if (remaining == 7'd1) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign T1  = (bit_cnt == 5'd0);
    assign T29 = (bit_cnt == LAST_BIT);
    assign CE  = ~word_num[0];

    assign in_run     = (state == S_RUN);
    assign TR         = in_run && (op_r != 2'b11);
    assign DU         = in_run && (op_r == 2'b01);
    assign KEY_RETURN = in_run && (op_r == 2'b11);
    assign SHIFT_INC  = in_run && (op_r == 2'b10) && T29;
    assign busy       = (state == S_ALIGN) || in_run;
    assign done       = (state == S_DONE) || (state == S_ERR);
    assign err        = (state == S_ERR);

endmodule

// File: tb/tb_acc_word_sequencer.sv
// tb/tb_acc_word_sequencer.sv - self-checking bench for acc_word_sequencer
module tb_acc_word_sequencer;

    localparam int WB = 29;
    localparam int DW = 108;

    logic       CLOCK = 1'b0;
    logic       rst_n;
    logic       bit_tick;
    logic       start;
    logic [1:0] op;
    logic [6:0] count;
    logic       abort;
    logic       T1, T29, CE;
    logic [6:0] word_num;
    logic       TR, DU, KEY_RETURN, SHIFT_INC, busy, done, err;

    acc_word_sequencer #(.WORD_BITS(WB), .DRUM_WORDS(DW)) dut (
        .CLOCK(CLOCK), .rst_n(rst_n), .bit_tick(bit_tick), .start(start),
        .op(op), .count(count), .abort(abort),
        .T1(T1), .T29(T29), .CE(CE), .word_num(word_num),
        .TR(TR), .DU(DU), .KEY_RETURN(KEY_RETURN), .SHIFT_INC(SHIFT_INC),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLOCK = ~CLOCK;

    int checks   = 0;
    int failures = 0;
    int vec_prints = 0;

    // Reference: absolute tick count since reset plus the active run window [m_s, m_e)
    int         m_ticks;
    bit         m_active, m_done, m_err;
    int         m_s, m_e;
    logic [1:0] m_op;

    int tr_ticks, du_ticks, kr_ticks, shift_rises, done_cnt, err_cnt;
    bit shift_prev, seen_tr;
    int first_tr_word, first_tr_t1;
    bit rnd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ticks = 0; m_active = 0; m_done = 0; m_err = 0;
        m_s = 0; m_e = 0; m_op = 2'b00;
    endtask

    task automatic model_edge();
        bit dn, er;
        dn = 0; er = 0;
        if (m_active) begin
            if (abort) m_active = 0;
            else if (bit_tick && (m_ticks + 1 == m_e)) begin
                m_active = 0; dn = 1;
            end
        end else if (!m_done && start) begin
            if (count == 7'd0) begin
                dn = 1; er = 1;
            end else begin
                m_active = 1;
                m_op = op;
                m_s = (m_ticks / WB + 1) * WB;
                m_e = m_s + int'(count) * WB;
            end
        end
        m_done = dn;
        m_err  = er;
        if (bit_tick) m_ticks++;
    endtask

    task automatic cmp_vec();
        int b, w;
        bit run;
        logic [16:0] exp_v, act_v;
        b = m_ticks % WB;
        w = (m_ticks / WB) % DW;
        run = m_active && (m_ticks >= m_s);
        exp_v = {b == 0, b == WB - 1, (w % 2) == 0, 7'(w),
                 run && (m_op != 2'b11), run && (m_op == 2'b01), run && (m_op == 2'b11),
                 run && (m_op == 2'b10) && (b == WB - 1), m_active, m_done, m_err};
        act_v = {T1, T29, CE, word_num, TR, DU, KEY_RETURN, SHIFT_INC, busy, done, err};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            if (vec_prints < 20)
                $display("FAIL cycle_vec t=%0t actual=%h expected=%h", $time, act_v, exp_v);
            vec_prints++;
        end
    endtask

    task automatic clear_counters();
        tr_ticks = 0; du_ticks = 0; kr_ticks = 0; shift_rises = 0;
        done_cnt = 0; err_cnt = 0; seen_tr = 0; first_tr_word = -1; first_tr_t1 = -1;
    endtask

    task automatic step();
        if (rnd) begin
            bit_tick = ($urandom_range(0, 3) != 0);
            abort    = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 19) == 0);
            op       = 2'($urandom_range(0, 3));
            count    = 7'($urandom_range(0, 4));
        end
        if (TR && bit_tick) tr_ticks++;
        if (DU && bit_tick) du_ticks++;
        if (KEY_RETURN && bit_tick) kr_ticks++;
        @(posedge CLOCK);
        model_edge();
        #1;
        cmp_vec();
        if (SHIFT_INC && !shift_prev) shift_rises++;
        shift_prev = SHIFT_INC;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (TR && !seen_tr) begin
            seen_tr = 1; first_tr_word = int'(word_num); first_tr_t1 = int'(T1);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_reached_done"}, int'(done_cnt > 0), 1);
        repeat (2) step();
    endtask

    task automatic advance_to(input int modulus, input int target, input int budget);
        int n;
        n = 0;
        while ((m_ticks % modulus) != target && n < budget) begin
            step();
            n++;
        end
        chk("advance_in_budget", int'((m_ticks % modulus) == target), 1);
    endtask

    initial begin
        rnd = 0; shift_prev = 0;
        rst_n = 1'b0; bit_tick = 1'b0; start = 1'b0; op = 2'b00; count = 7'd0; abort = 1'b0;
        model_reset();
        clear_counters();
        repeat (3) @(posedge CLOCK);
        #1;
        chk("reset_T1", T1, 1);
        chk("reset_T29", T29, 0);
        chk("reset_CE", CE, 1);
        chk("reset_word", word_num, 0);
        chk("reset_ctrl", {TR, DU, KEY_RETURN, SHIFT_INC, busy, done, err}, 0);
        rst_n = 1'b1;

        // Drum timing and word wrap
        bit_tick = 1'b1;
        repeat (WB) step();
        chk("word1_num", word_num, 1);
        chk("word1_CE", CE, 0);
        chk("word1_T1", T1, 1);
        repeat (WB * DW - WB) step();
        chk("wrap_word", word_num, 0);
        chk("wrap_T1", T1, 1);

        // op 00, count 3, started at bit 10 of word 5
        repeat (5 * WB + 10) step();
        chk("w5_word", word_num, 5);
        clear_counters();
        op = 2'b00; count = 7'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("add3", 400);
        chk("add3_tr_ticks", tr_ticks, 87);
        chk("add3_first_word", first_tr_word, 6);
        chk("add3_first_T1", first_tr_t1, 1);
        chk("add3_done_cnt", done_cnt, 1);
        chk("add3_err_cnt", err_cnt, 0);

        // op 01, count 1, coincident with word end of word 107
        advance_to(WB * DW, WB * DW - 1, 4000);
        clear_counters();
        op = 2'b01; count = 7'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("xfer1", 100);
        chk("xfer1_du_ticks", du_ticks, 29);
        chk("xfer1_tr_ticks", tr_ticks, 29);
        chk("xfer1_first_word", first_tr_word, 0);
        chk("xfer1_done_cnt", done_cnt, 1);

        // op 10, count 2, with sparse bit ticks
        clear_counters();
        op = 2'b10; count = 7'd2; start = 1'b1;
        step();
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (done_cnt == 0 && n < 1000) begin
                bit_tick = ($urandom_range(0, 2) != 0);
                step();
                n++;
            end
        end
        chk("shift2_reached_done", int'(done_cnt > 0), 1);
        bit_tick = 1'b1;
        repeat (2) step();
        chk("shift2_rises", shift_rises, 2);
        chk("shift2_tr_ticks", tr_ticks, 58);

        // count 0 rejected
        bit_tick = 1'b0;
        clear_counters();
        op = 2'b00; count = 7'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("err_done", done, 1);
        chk("err_err", err, 1);
        chk("err_tr", TR, 0);
        step();
        chk("err_done_single", done, 0);

        // start while busy is ignored
        bit_tick = 1'b1;
        clear_counters();
        op = 2'b00; count = 7'd2; start = 1'b1;
        step();
        op = 2'b11; count = 7'd5;
        repeat (10) step();
        start = 1'b0;
        wait_done("busy_ign", 200);
        chk("busy_ign_tr_ticks", tr_ticks, 58);
        chk("busy_ign_kr_ticks", kr_ticks, 0);
        chk("busy_ign_done_cnt", done_cnt, 1);

        // abort in RUN during word 2 of 5
        advance_to(WB, WB - 1, 100);
        clear_counters();
        op = 2'b00; count = 7'd5; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2 * WB + 10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_tr", TR, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_tr_ticks", tr_ticks, 69);
        repeat (200) step();
        chk("abort_no_done", done_cnt, 0);

        // asynchronous reset mid-operation
        advance_to(WB, WB - 1, 100);
        clear_counters();
        op = 2'b01; count = 7'd5; start = 1'b1;
        step();
        start = 1'b0;
        repeat (40) step();
        chk("pre_rst_du", DU, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_T1", T1, 1);
        chk("arst_T29", T29, 0);
        chk("arst_CE", CE, 1);
        chk("arst_word", word_num, 0);
        chk("arst_ctrl", {TR, DU, KEY_RETURN, SHIFT_INC, busy, done, err}, 0);
        @(posedge CLOCK);
        #1;
        cmp_vec();
        rst_n = 1'b1;
        repeat (300) step();
        chk("arst_no_done", done_cnt, 0);

        // randomized traffic against the reference
        rnd = 1;
        repeat (20000) step();
        rnd = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
